// File: rtl/gpio_exti_lbus.sv
// GPIO external-interrupt block: per-pin sync, debounce, edge detect,
// W1C pending bits and a registered IRQ, on the local-bus slave port.
package gpio_exti_lbus_pkg;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } lb_slave_t;

  function automatic logic MatchWLB(lb_slave_t lb, logic [7:0] a);
    return lb.wr && (lb.addr == a);
  endfunction

  function automatic logic MatchRLB(lb_slave_t lb, logic [7:0] a);
    return lb.rd && (lb.addr == a);
  endfunction

endpackage

module gpio_exti_lbus
  import gpio_exti_lbus_pkg::*;
#(
  parameter int          NUM       = 10,
  parameter logic [7:0]  BASE_ADDR = 8'd20,
  parameter int          DIV_W     = 16
) (
  input  logic            lb_clk,
  input  logic            rst,
  input  lb_slave_t       xt_lb,
  output logic [31:0]     rdata,
  input  logic [NUM-1:0]  gpio_in,
  output logic            irq
);

  localparam logic [7:0] A_RISE = BASE_ADDR;
  localparam logic [7:0] A_FALL = BASE_ADDR + 8'd4;
  localparam logic [7:0] A_PEND = BASE_ADDR + 8'd8;
  localparam logic [7:0] A_CFG  = BASE_ADDR + 8'd12;
  localparam logic [7:0] A_LVL  = BASE_ADDR + 8'd16;

  logic [NUM-1:0]   r_rise_en;
  logic [NUM-1:0]   r_fall_en;
  logic [NUM-1:0]   r_pend;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_thr;
  logic [NUM-1:0]   r_s1;
  logic [NUM-1:0]   r_s2;
  logic [NUM-1:0]   r_lvl;
  logic [3:0]       r_cnt [NUM];
  logic [DIV_W-1:0] r_pcnt;
  logic             r_irq;

  logic             w_cfg_wr;
  logic             w_tick;
  logic [NUM-1:0]   w_lvl_nxt;
  logic [3:0]       w_cnt_nxt [NUM];
  logic [NUM-1:0]   w_set;
  logic [NUM-1:0]   w_w1c;
  logic             w_unused;

  assign w_unused = ^xt_lb.wdata;
  assign w_cfg_wr = MatchWLB(xt_lb, A_CFG);
  // A config write restarts the prescaler, so that cycle is never a tick.
  assign w_tick   = (r_pcnt == r_div) && !w_cfg_wr;
  assign w_w1c    = MatchWLB(xt_lb, A_PEND) ? xt_lb.wdata[NUM-1:0] : '0;
  assign w_set    = (w_lvl_nxt & ~r_lvl & r_rise_en)
                  | (~w_lvl_nxt & r_lvl & r_fall_en);
  assign irq      = r_irq;

  // Combinational register read mux; unmatched reads return 0.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      MatchRLB(xt_lb, A_RISE): rdata = 32'(r_rise_en);
      MatchRLB(xt_lb, A_FALL): rdata = 32'(r_fall_en);
      MatchRLB(xt_lb, A_PEND): rdata = 32'(r_pend);
      MatchRLB(xt_lb, A_CFG):  rdata = {12'd0, r_thr, 16'(r_div)};
      MatchRLB(xt_lb, A_LVL):  rdata = 32'(r_lvl);
      default:                 rdata = '0;
    endcase
  end

  // Debounce filter next state per pin; THR=0 bypasses the counter.
  always_comb begin
    w_lvl_nxt = r_lvl;
    for (int i = 0; i < NUM; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_thr == 4'd0) begin
        w_lvl_nxt[i] = r_s2[i];
        w_cnt_nxt[i] = '0;
      end else if (r_s2[i] == r_lvl[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (w_tick) begin
        if (r_cnt[i] + 4'd1 == r_thr) begin
          w_lvl_nxt[i] = r_s2[i];
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
      end
      if (w_cfg_wr) w_cnt_nxt[i] = '0;
    end
  end

  // Bus registers and W1C pending; a new edge beats a same-cycle clear.
  always_ff @(posedge lb_clk) begin
    if (rst) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_pend    <= '0;
      r_div     <= '0;
      r_thr     <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (MatchWLB(xt_lb, A_RISE)) r_rise_en <= xt_lb.wdata[NUM-1:0];
      if (MatchWLB(xt_lb, A_FALL)) r_fall_en <= xt_lb.wdata[NUM-1:0];
      if (w_cfg_wr) begin
        r_div <= xt_lb.wdata[DIV_W-1:0];
        r_thr <= xt_lb.wdata[19:16];
      end
      r_pend <= (r_pend & ~w_w1c) | w_set;
      r_irq  <= |r_pend;
    end
  end

  // Two-flop synchroniser, prescaler and filter state.
  always_ff @(posedge lb_clk) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_lvl  <= '0;
      r_pcnt <= '0;
      for (int i = 0; i < NUM; i++) r_cnt[i] <= '0;
    end else begin
      r_s1  <= gpio_in;
      r_s2  <= r_s1;
      r_lvl <= w_lvl_nxt;
      if (w_cfg_wr || (r_pcnt == r_div)) r_pcnt <= '0;
      else r_pcnt <= r_pcnt + 1'b1;
      for (int i = 0; i < NUM; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_gpio_exti_lbus.sv
// Directed bench for gpio_exti_lbus: queued expectations checked
// by immediate assertions as each DUT observation is taken.
module tb_gpio_exti_lbus;
  import gpio_exti_lbus_pkg::*;

  localparam int NUM = 10;
  localparam logic [7:0] B      = 8'd20;
  localparam logic [7:0] A_RISE = B;
  localparam logic [7:0] A_FALL = B + 8'd4;
  localparam logic [7:0] A_PEND = B + 8'd8;
  localparam logic [7:0] A_CFG  = B + 8'd12;
  localparam logic [7:0] A_LVL  = B + 8'd16;
  localparam logic [7:0] A_NONE = B + 8'd20;
  localparam logic [31:0] CFG43 = 32'h0004_0003;
  localparam logic [31:0] CFG33 = 32'h0003_0003;

  logic            clk = 1'b0;
  logic            rst;
  lb_slave_t       xt_lb;
  logic [31:0]     rdata;
  logic [NUM-1:0]  gpio_in;
  logic            irq;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  gpio_exti_lbus #(.NUM(NUM), .BASE_ADDR(B), .DIV_W(16)) dut (
    .lb_clk  (clk),
    .rst     (rst),
    .xt_lb   (xt_lb),
    .rdata   (rdata),
    .gpio_in (gpio_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard: queue empty, observed %h", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    xt_lb.wr    = 1'b1;
    xt_lb.addr  = a;
    xt_lb.wdata = d;
    @(negedge clk);
    xt_lb.wr    = 1'b0;
    xt_lb.wdata = '0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    xt_lb.rd   = 1'b1;
    xt_lb.addr = a;
    #1;
    d = rdata;
    xt_lb.rd = 1'b0;
  endtask

  task automatic rd_chk(input string t, input logic [7:0] a,
                        input logic [31:0] e);
    logic [31:0] d;
    push(t, e);
    bus_rd(a, d);
    check(d);
  endtask

  task automatic irq_chk(input string t, input logic e);
    push(t, {31'd0, e});
    check({31'd0, irq});
  endtask

  task automatic cyc_chk(input string t, input int got, input int e);
    push(t, 32'(e));
    check(32'(got));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] d;
    rst     = 1'b1;
    xt_lb   = '0;
    gpio_in = '1;
    repeat (2) @(negedge clk);
    rd_chk("rst_level", A_LVL, 32'h0);
    rd_chk("rst_cfg", A_CFG, 32'h0);
    irq_chk("rst_irq", 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus_wr(A_RISE, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    rd_chk("rise_en_mask", A_RISE, 32'h3FF);
    rd_chk("boot_level", A_LVL, 32'h3FF);
    rd_chk("boot_pend", A_PEND, 32'h0);
    irq_chk("boot_irq", 1'b0);

    gpio_in = '0;
    repeat (5) @(negedge clk);
    bus_wr(A_RISE, 32'h4);
    bus_wr(A_PEND, 32'hFFFF_FFFF);
    gpio_in = 10'h004;
    @(negedge clk);
    @(negedge clk);
    rd_chk("byp_pend_k1", A_PEND, 32'h0);
    @(negedge clk);
    rd_chk("byp_pend_k2", A_PEND, 32'h4);
    irq_chk("byp_irq_k2", 1'b0);
    @(negedge clk);
    irq_chk("byp_irq_k3", 1'b1);
    bus_wr(A_PEND, 32'h4);
    rd_chk("w1c_pend", A_PEND, 32'h0);
    irq_chk("w1c_irq_lag", 1'b1);
    @(negedge clk);
    irq_chk("w1c_irq", 1'b0);

    bus_wr(A_FALL, 32'h1);
    bus_wr(A_CFG, CFG43);
    rd_chk("cfg_rb", A_CFG, CFG43);
    gpio_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("deb_rise_lvl", A_LVL, 32'h5);
    rd_chk("deb_rise_pend", A_PEND, 32'h0);

    gpio_in[0] = 1'b0;
    bus_wr(A_CFG, CFG43);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus_rd(A_LVL, d);
      if (!d[0]) break;
    end
    cyc_chk("deb_fall_cycles", cyc, 16);
    rd_chk("deb_fall_pend", A_PEND, 32'h1);
    @(negedge clk);
    irq_chk("deb_fall_irq", 1'b1);
    bus_wr(A_PEND, 32'h1);

    gpio_in[0] = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("glitch_pre_lvl", A_LVL, 32'h5);
    gpio_in[0] = 1'b0;
    bus_wr(A_CFG, CFG43);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) gpio_in[0] = 1'b1;
      if (cyc == 6) gpio_in[0] = 1'b0;
      bus_rd(A_LVL, d);
      if (!d[0]) break;
    end
    cyc_chk("glitch_fall_cycles", cyc, 24);
    rd_chk("glitch_pend", A_PEND, 32'h1);
    bus_wr(A_PEND, 32'h1);

    bus_wr(A_RISE, 32'h5);
    gpio_in[0] = 1'b1;
    bus_wr(A_CFG, CFG33);
    repeat (6) @(negedge clk);
    gpio_in[0] = 1'b0;
    repeat (30) @(negedge clk);
    rd_chk("short_pulse_lvl", A_LVL, 32'h4);
    rd_chk("short_pulse_pend", A_PEND, 32'h0);

    bus_wr(A_CFG, 32'h0);
    repeat (3) @(negedge clk);
    gpio_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_chk("race_pre_pend", A_PEND, 32'h0);
    bus_wr(A_PEND, 32'h1);
    rd_chk("race_pend", A_PEND, 32'h1);
    @(negedge clk);
    irq_chk("race_irq_a", 1'b1);
    @(negedge clk);
    irq_chk("race_irq_b", 1'b1);

    rd_chk("unmapped", A_NONE, 32'h0);
    bus_wr(A_LVL, 32'h0);
    rd_chk("level_ro", A_LVL, 32'h5);
    bus_wr(A_RISE, 32'h0);
    rd_chk("disable_keeps_pend", A_PEND, 32'h1);
    irq_chk("disable_keeps_irq", 1'b1);
    bus_wr(A_PEND, 32'hFFFF_FFFF);
    rd_chk("clear_all", A_PEND, 32'h0);

    gpio_in[0] = 1'b0;
    bus_wr(A_CFG, CFG43);
    repeat (10) @(negedge clk);
    rd_chk("midcfg_lvl", A_LVL, 32'h5);
    bus_wr(A_CFG, CFG43);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus_rd(A_LVL, d);
      if (!d[0]) break;
    end
    cyc_chk("midcfg_fall_cycles", cyc, 16);
    rd_chk("midcfg_pend", A_PEND, 32'h1);

    gpio_in[0] = 1'b1;
    bus_wr(A_CFG, CFG43);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rd_chk("midrst_pend", A_PEND, 32'h0);
    rd_chk("midrst_lvl", A_LVL, 32'h0);
    irq_chk("midrst_irq", 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("postrst_lvl", A_LVL, 32'h5);
    rd_chk("postrst_pend", A_PEND, 32'h0);
    rd_chk("postrst_cfg", A_CFG, 32'h0);
    irq_chk("postrst_irq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
